// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory port, hazard/redirect controls and IF/ID outputs.
// align_exc exists only when FETCH_ALIGN_CHECK_EN is defined.
interface fetch_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        jump_en;
    logic [31:0] jump_target;
    logic        br_en;
    logic [31:0] br_target;
    logic        irq;
    logic        exc;
    logic        irq_taken;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        align_exc;
`endif

    modport master (
        output imem_instr, stall, jump_en, jump_target, br_en, br_target, irq, exc,
        input  imem_addr, irq_taken, if_id_instr, if_id_pc4, if_id_valid
`ifdef FETCH_ALIGN_CHECK_EN
        , input align_exc
`endif
    );

    modport slave (
        input  imem_instr, stall, jump_en, jump_target, br_en, br_target, irq, exc,
        output imem_addr, irq_taken, if_id_instr, if_id_pc4, if_id_valid
`ifdef FETCH_ALIGN_CHECK_EN
        , output align_exc
`endif
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection and the IF/ID register.
// Optional FETCH_ALIGN_CHECK_EN turns misaligned jump/branch targets into an exception.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] IRQ_VEC  = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC  = 32'h8000_0008
) (
    input logic         clk,
    input logic         reset,
    fetch_stage_if.slave bus
);
    logic [31:0] pc;
    logic [31:0] pc_seq;
    logic [31:0] pc_next;
    logic        irq_acc;
    logic        bad_target;
    logic        redirect;

    // Bit 31 is the kernel-mode flag and is never carried into by the increment.
    assign pc_seq        = {pc[31], pc[30:0] + 31'd4};
    assign irq_acc       = bus.irq & ~pc[31] & ~bus.exc;
    assign bus.imem_addr = pc;
    assign bus.irq_taken = irq_acc & ~reset;

`ifdef FETCH_ALIGN_CHECK_EN
    logic [31:0] target;
    assign target        = bus.br_en ? bus.br_target : bus.jump_target;
    assign bad_target    = (bus.br_en | bus.jump_en) & ~bus.exc & ~irq_acc & (target[1:0] != 2'b00);
    assign bus.align_exc = bad_target & ~reset;
`else
    assign bad_target    = 1'b0;
`endif

    always_comb begin
        redirect = bus.exc | irq_acc | bus.br_en | bus.jump_en;
        pc_next  = pc_seq;
        if (bus.exc || bad_target) pc_next = EXC_VEC;
        else if (irq_acc)          pc_next = IRQ_VEC;
        else if (bus.br_en)        pc_next = bus.br_target;
        else if (bus.jump_en)      pc_next = bus.jump_target;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc              <= RESET_PC;
            bus.if_id_instr <= 32'd0;
            bus.if_id_pc4   <= 32'd0;
            bus.if_id_valid <= 1'b0;
        end else if (redirect) begin
            // Every redirect discards the word fetched this cycle, stall or not.
            pc              <= pc_next;
            bus.if_id_instr <= 32'd0;
            bus.if_id_pc4   <= 32'd0;
            bus.if_id_valid <= 1'b0;
        end else if (!bus.stall) begin
            pc              <= pc_seq;
            bus.if_id_instr <= bus.imem_instr;
            bus.if_id_pc4   <= pc_seq;
            bus.if_id_valid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed corner cases followed by random redirect/stall traffic.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_stage_if bus ();
    fetch_stage dut (.clk(clk), .reset(reset), .bus(bus));

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction
    assign bus.imem_instr = mem_word(bus.imem_addr);

    typedef struct {
        bit          chk_comb;
        logic [31:0] exp_addr;
        bit          exp_irq;
        bit          exp_align;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc4;
        bit          exp_valid;
    } rec_t;

    rec_t q[$];
    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_pc, m_instr, m_pc4;
    bit          m_valid;
    bit          m_known = 0;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: PC rules written directly as address arithmetic.
    task automatic issue(input bit rst, input bit st, input bit je, input logic [31:0] jt,
                         input bit be, input logic [31:0] bt, input bit iq, input bit ex);
        rec_t r;
        bit acc, bad;
        logic [31:0] seq, tgt;
        @(negedge clk);
        reset = rst; bus.stall = st; bus.jump_en = je; bus.jump_target = jt;
        bus.br_en = be; bus.br_target = bt; bus.irq = iq; bus.exc = ex;
        r.chk_comb = m_known; r.exp_addr = m_pc; r.exp_align = 0; r.exp_irq = 0;
        if (rst) begin
            m_pc = 32'h8000_0000; m_instr = 0; m_pc4 = 0; m_valid = 0; m_known = 1;
        end else begin
            acc = iq && (m_pc < 32'h8000_0000) && !ex;
            seq = (m_pc & 32'h8000_0000) | ((m_pc + 32'd4) & 32'h7FFF_FFFF);
            tgt = be ? bt : jt;
            bad = ALIGN && !ex && !acc && (be || je) && (tgt % 4 != 0);
            r.exp_irq = acc; r.exp_align = bad;
            if (ex || bad || acc || be || je) begin
                m_pc = (ex || bad) ? 32'h8000_0008 : acc ? 32'h8000_0004 : tgt;
                m_instr = 0; m_pc4 = 0; m_valid = 0;
            end else if (!st) begin
                m_instr = mem_word(m_pc); m_pc4 = seq; m_valid = 1; m_pc = seq;
            end
        end
        r.exp_pc = m_pc; r.exp_instr = m_instr; r.exp_pc4 = m_pc4; r.exp_valid = m_valid;
        q.push_back(r);
    endtask

    task automatic idle();
        issue(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic br_to(input logic [31:0] t);
        issue(0, 0, 0, 0, 1, t, 0, 0);
    endtask

    initial begin : monitor
        rec_t r;
        forever begin
            @(negedge clk); #2;
            if (q.size() > 0) begin
                r = q.pop_front();
                if (r.chk_comb) begin
                    check("imem_addr", bus.imem_addr, r.exp_addr);
                    check("irq_taken", {31'd0, bus.irq_taken}, {31'd0, r.exp_irq});
`ifdef FETCH_ALIGN_CHECK_EN
                    check("align_exc", {31'd0, bus.align_exc}, {31'd0, r.exp_align});
`endif
                end
                @(posedge clk); #1;
                check("pc", bus.imem_addr, r.exp_pc);
                check("if_id_instr", bus.if_id_instr, r.exp_instr);
                check("if_id_pc4", bus.if_id_pc4, r.exp_pc4);
                check("if_id_valid", {31'd0, bus.if_id_valid}, {31'd0, r.exp_valid});
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [31:0] jt, bt;
        reset = 1; bus.stall = 0; bus.jump_en = 0; bus.jump_target = 0;
        bus.br_en = 0; bus.br_target = 0; bus.irq = 0; bus.exc = 0;
        issue(1, 0, 0, 0, 0, 0, 0, 0);
        issue(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) idle();
        br_to(32'h0000_000C);
        repeat (2) issue(0, 1, 0, 0, 0, 0, 0, 0);
        repeat (3) idle();
        issue(0, 1, 1, 32'h0000_0080, 1, 32'h0000_0040, 0, 0);
        idle();
        br_to(32'h0000_0010);
        issue(0, 0, 0, 0, 0, 0, 1, 0);
        repeat (3) issue(0, 0, 0, 0, 0, 0, 1, 0);
        br_to(32'h0000_0020);
        issue(0, 0, 0, 0, 0, 0, 1, 1);
        br_to(32'h7FFF_FFFC);
        repeat (2) idle();
        br_to(32'hFFFF_FFFC);
        repeat (2) idle();
        issue(0, 0, 1, 32'h0000_0102, 0, 0, 0, 0);
        br_to(32'h0000_0042);
        repeat (2) idle();
        repeat (2000) begin
            jt = $urandom; bt = $urandom;
            if ($urandom_range(3) != 0) jt[1:0] = 2'b00;
            if ($urandom_range(3) != 0) bt[1:0] = 2'b00;
            if ($urandom_range(1) != 0) jt[31] = 1'b0;
            if ($urandom_range(1) != 0) bt[31] = 1'b0;
            issue($urandom_range(99) == 0, $urandom_range(3) == 0,
                  $urandom_range(7) == 0, jt, $urandom_range(7) == 0, bt,
                  $urandom_range(5) == 0, $urandom_range(19) == 0);
        end
        repeat (3) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
